wb_arbiter: RTL and testbench

- Writeback arbiter that feeds the register file's single write port (save_enable / save_address / save_value).
- Merges two result sources:
  - single-cycle ALU results, with priority;
  - long-latency load results, buffered in a small FIFO.
- Also keeps a per-register pending scoreboard that the issue stage uses to stall RAW hazards on outstanding loads.

---
 rtl/wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and FIFO-buffered load results
// onto the register file's single write port, and tracks outstanding loads per register.
module wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LQ_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic [31:0]     pending_mask,
    output logic            save_enable,
    output logic [4:0]      save_address,
    output logic [XLEN-1:0] save_value
);

    localparam int unsigned AW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int unsigned CW = $clog2(LQ_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(LQ_DEPTH);
    localparam logic [SW-1:0] C_LIMIT = SW'(STARVE_LIMIT);

    logic [4:0]      r_lq_rd   [LQ_DEPTH];
    logic [XLEN-1:0] r_lq_data [LQ_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_starve;
    logic [31:0]     r_pending;
    logic            r_save_en;
    logic [4:0]      r_save_addr;
    logic [XLEN-1:0] r_save_val;

    logic            w_empty;
    logic            w_force;
    logic            w_push;
    logic            w_pop;
    logic            w_alu_sel;
    logic            w_sel;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_val;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;

    assign w_empty     = (r_count == '0);
    assign ld_ready    = (r_count < C_DEPTH);
    assign w_push      = ld_valid && ld_ready;
    assign w_head_rd   = r_lq_rd[r_rptr];
    assign w_head_data = r_lq_data[r_rptr];
    assign w_force     = (r_starve == C_LIMIT) && !w_empty;
    assign alu_ready   = !w_force;

    // A forced pop overrides the ALU; otherwise the ALU wins and loads fill idle slots.
    always_comb begin
        w_pop     = 1'b0;
        w_alu_sel = 1'b0;
        w_sel_rd  = '0;
        w_sel_val = '0;
        if (w_force) begin
            w_pop     = 1'b1;
            w_sel_rd  = w_head_rd;
            w_sel_val = w_head_data;
        end else if (alu_valid) begin
            w_alu_sel = 1'b1;
            w_sel_rd  = alu_rd;
            w_sel_val = alu_result;
        end else if (!w_empty) begin
            w_pop     = 1'b1;
            w_sel_rd  = w_head_rd;
            w_sel_val = w_head_data;
        end
    end

    assign w_sel = w_pop || w_alu_sel;
    assign w_set = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : '0;
    assign w_clr = w_pop ? (32'd1 << w_head_rd) : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lq_rd[r_wptr]   <= ld_rd;
            r_lq_data[r_wptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_empty || w_pop) begin
            r_starve <= '0;
        end else if (w_alu_sel && (r_starve != C_LIMIT)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_clr) | w_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_save_en   <= 1'b0;
            r_save_addr <= '0;
            r_save_val  <= '0;
        end else begin
            r_save_en <= w_sel && (w_sel_rd != 5'd0);
            if (w_sel) begin
                r_save_addr <= w_sel_rd;
                r_save_val  <= w_sel_val;
            end
        end
    end

    assign pending_mask = r_pending;
    assign save_enable  = r_save_en;
    assign save_address = r_save_addr;
    assign save_value   = r_save_val;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] pending_mask;
    logic        save_enable;
    logic [4:0]  save_address;
    logic [31:0] save_value;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(32), .LQ_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .pending_mask(pending_mask),
        .save_enable(save_enable), .save_address(save_address), .save_value(save_value)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (save_enable !== 1'b0) begin n_err++; $display("FAIL reset_save_en got %b exp 0", save_enable); end
        n_vec++; if (save_address !== 5'd0) begin n_err++; $display("FAIL reset_save_addr got %0d exp 0", save_address); end
        n_vec++; if (save_value !== 32'd0) begin n_err++; $display("FAIL reset_save_val got %h exp 0", save_value); end
        n_vec++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL reset_pending got %h exp 0", pending_mask); end
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready got %b exp 1", ld_ready); end
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_alu_ready got %b exp 1", alu_ready); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready got %b exp 1", alu_ready); end
        step();
        alu_valid = 1'b0;
        n_vec++; if (save_enable !== 1'b1) begin n_err++; $display("FAIL alu_save_en got %b exp 1", save_enable); end
        n_vec++; if (save_address !== 5'd5) begin n_err++; $display("FAIL alu_save_addr got %0d exp 5", save_address); end
        n_vec++; if (save_value !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_save_val got %h exp deadbeef", save_value); end
        step();
        n_vec++; if (save_enable !== 1'b0) begin n_err++; $display("FAIL alu_idle_en got %b exp 0", save_enable); end
        n_vec++; if (save_value !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_hold_val got %h exp deadbeef", save_value); end
        n_vec++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL alu_pending got %h exp 0", pending_mask); end
    endtask

    task automatic test_load_path();
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        n_vec++; if (pending_mask !== 32'h0000_0080) begin n_err++; $display("FAIL ld_pending_set got %h exp 00000080", pending_mask); end
        step(); step(); step();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_1234;
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL ld_ready got %b exp 1", ld_ready); end
        step();
        ld_valid = 1'b0;
        n_vec++; if (save_enable !== 1'b0) begin n_err++; $display("FAIL ld_no_bypass got %b exp 0", save_enable); end
        n_vec++; if (pending_mask !== 32'h0000_0080) begin n_err++; $display("FAIL ld_pending_hold got %h exp 00000080", pending_mask); end
        step();
        n_vec++; if (save_enable !== 1'b1) begin n_err++; $display("FAIL ld_save_en got %b exp 1", save_enable); end
        n_vec++; if (save_address !== 5'd7) begin n_err++; $display("FAIL ld_save_addr got %0d exp 7", save_address); end
        n_vec++; if (save_value !== 32'h0000_1234) begin n_err++; $display("FAIL ld_save_val got %h exp 00001234", save_value); end
        n_vec++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL ld_pending_clr got %h exp 0", pending_mask); end
        step();
        n_vec++; if (save_enable !== 1'b0) begin n_err++; $display("FAIL ld_after_en got %b exp 0", save_enable); end
    endtask

    task automatic test_starvation();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'd100;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_AAAA;
        step();
        ld_valid = 1'b0;
        n_vec++; if (save_address !== 5'd3 || save_value !== 32'd100) begin n_err++; $display("FAIL starve_first_alu got %0d/%h exp 3/00000064", save_address, save_value); end
        for (int i = 1; i <= 4; i++) begin
            alu_result = 32'(100 + i);
            n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_alu_ready_%0d got %b exp 1", i, alu_ready); end
            step();
            n_vec++; if (save_enable !== 1'b1 || save_address !== 5'd3 || save_value !== 32'(100 + i)) begin
                n_err++; $display("FAIL starve_alu_win_%0d got %b/%0d/%h exp 1/3/%h", i, save_enable, save_address, save_value, 32'(100 + i));
            end
        end
        n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL starve_force_ready got %b exp 0", alu_ready); end
        step();
        n_vec++; if (save_enable !== 1'b1 || save_address !== 5'd9 || save_value !== 32'h0000_AAAA) begin
            n_err++; $display("FAIL starve_forced_ld got %b/%0d/%h exp 1/9/0000aaaa", save_enable, save_address, save_value);
        end
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_ready_back got %b exp 1", alu_ready); end
        step();
        alu_valid = 1'b0;
        n_vec++; if (save_address !== 5'd3 || save_value !== 32'd104) begin n_err++; $display("FAIL starve_held_alu got %0d/%h exp 3/00000068", save_address, save_value); end
        step();
    endtask

    task automatic test_fifo_full();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_result = 32'h0000_0044;
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h0000_A0A0;
        step();
        ld_rd = 5'd11; ld_data = 32'h0000_B0B0;
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_1 got %b exp 1", ld_ready); end
        step();
        ld_rd = 5'd12; ld_data = 32'h0000_C0C0;
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_0 got %b exp 0", ld_ready); end
        step();
        ld_valid = 1'b0;
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL full_reject got %b exp 0", ld_ready); end
        step(); step();
        n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL full_force_a got %b exp 0", alu_ready); end
        step();
        n_vec++; if (save_address !== 5'd10 || save_value !== 32'h0000_A0A0) begin n_err++; $display("FAIL full_order_a got %0d/%h exp 10/0000a0a0", save_address, save_value); end
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after_pop got %b exp 1", ld_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (save_address !== 5'd4) begin n_err++; $display("FAIL full_alu_win_%0d got %0d exp 4", i, save_address); end
        end
        n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL full_force_b got %b exp 0", alu_ready); end
        step();
        alu_valid = 1'b0;
        n_vec++; if (save_address !== 5'd11 || save_value !== 32'h0000_B0B0) begin n_err++; $display("FAIL full_order_b got %0d/%h exp 11/0000b0b0", save_address, save_value); end
        step(); step();
        n_vec++; if (save_enable !== 1'b0) begin n_err++; $display("FAIL full_no_c got %b exp 0", save_enable); end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'h0000_0055;
        step();
        alu_valid = 1'b0;
        n_vec++; if (save_enable !== 1'b0) begin n_err++; $display("FAIL x0_alu_en got %b exp 0", save_enable); end
        n_vec++; if (save_address !== 5'd0 || save_value !== 32'h0000_0055) begin n_err++; $display("FAIL x0_alu_regs got %0d/%h exp 0/00000055", save_address, save_value); end
        issue_valid = 1'b1; issue_rd = 5'd2;
        step();
        issue_rd = 5'd0;
        step();
        issue_valid = 1'b0;
        n_vec++; if (pending_mask !== 32'h0000_0004) begin n_err++; $display("FAIL x0_issue got %h exp 00000004", pending_mask); end
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0000_0077;
        step();
        ld_valid = 1'b0;
        step();
        n_vec++; if (save_enable !== 1'b0) begin n_err++; $display("FAIL x0_load_en got %b exp 0", save_enable); end
        n_vec++; if (pending_mask !== 32'h0000_0004) begin n_err++; $display("FAIL x0_load_pending got %h exp 00000004", pending_mask); end
        ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h0000_0022;
        step();
        ld_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd2;
        step();
        issue_valid = 1'b0;
        n_vec++; if (save_enable !== 1'b1 || save_address !== 5'd2) begin n_err++; $display("FAIL set_wins_write got %b/%0d exp 1/2", save_enable, save_address); end
        n_vec++; if (pending_mask !== 32'h0000_0004) begin n_err++; $display("FAIL set_wins_pending got %h exp 00000004", pending_mask); end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_result = 32'h0000_0066;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_7777;
        step();
        ld_valid = 1'b0;
        n_vec++; if (save_enable !== 1'b1 || pending_mask !== 32'h0000_0080) begin n_err++; $display("FAIL arst_pre got %b/%h exp 1/00000080", save_enable, pending_mask); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (save_enable !== 1'b0) begin n_err++; $display("FAIL arst_save_en got %b exp 0", save_enable); end
        n_vec++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL arst_pending got %h exp 0", pending_mask); end
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL arst_ld_ready got %b exp 1", ld_ready); end
        alu_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_vec++; if (save_enable !== 1'b0) begin n_err++; $display("FAIL arst_no_write_1 got %b exp 0", save_enable); end
        step();
        n_vec++; if (save_enable !== 1'b0 || pending_mask !== 32'd0) begin n_err++; $display("FAIL arst_no_write_2 got %b/%h exp 0/0", save_enable, pending_mask); end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_load_path();
        test_starvation();
        test_fifo_full();
        test_x0();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
